// File: rtl/sys_clk_div_pkg.sv
// Shared types and constants for the programmable UART bit-rate clock divider.
package sys_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    // Smallest ratio that actually divides; anything below passes the reference clock through.
    localparam int unsigned MIN_RATIO = 32'd2;

endpackage

// File: rtl/sys_clk_div_if.sv
// Control/output bundle of the clock divider: enable and ratio in, divided clock and tick out.
interface sys_clk_div_if #(
    parameter int unsigned RATIO_W = 8
);
    logic               i_clk_en;
    logic [RATIO_W-1:0] i_div_ratio;
    logic               o_div_clk;
    logic               o_tick;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_tick
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_tick
    );
endinterface

// File: rtl/sys_clk_div.sv
// Runtime-programmable integer clock divider with bypass and an i_clk-domain tick
// marking each rising edge of the divided clock.
module sys_clk_div #(
    parameter int unsigned RATIO_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sys_clk_div_if.slave  bus
);
    import sys_clk_div_pkg::*;

    localparam logic [RATIO_W-1:0] ZERO_C      = {RATIO_W{1'b0}};
    localparam logic [RATIO_W-1:0] ONE_C       = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] MIN_RATIO_C = RATIO_W'(MIN_RATIO);

    state_t             state_r;
    logic [RATIO_W-1:0] cnt_r;
    logic [RATIO_W-1:0] ratio_r;
    logic               div_r;
    logic               tick_r;
    logic               bypass_sel_r;

    logic               start_ok_s;
    logic [RATIO_W-1:0] hi_len_s;
    logic [RATIO_W-1:0] hi_last_s;
    logic [RATIO_W-1:0] lo_last_s;

    // Phase limits come only from the latched ratio so a mid-period reprogram cannot truncate a phase.
    assign start_ok_s = bus.i_clk_en && (bus.i_div_ratio >= MIN_RATIO_C);
    assign hi_len_s   = ratio_r >> 1;
    assign hi_last_s  = hi_len_s - ONE_C;
    assign lo_last_s  = ratio_r - hi_len_s - ONE_C;

    // Divider FSM: state, phase counter, latched ratio, divided-clock level, tick and clock-mux select.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO_C;
            ratio_r      <= ZERO_C;
            div_r        <= 1'b0;
            tick_r       <= 1'b0;
            bypass_sel_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, BYPASS: begin
                    if (start_ok_s) begin
                        state_r      <= HIGH;
                        ratio_r      <= bus.i_div_ratio;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b1;
                        tick_r       <= 1'b1;
                        bypass_sel_r <= 1'b0;
                    end else begin
                        state_r      <= BYPASS;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b0;
                        tick_r       <= 1'b1;
                        bypass_sel_r <= 1'b1;
                    end
                end
                HIGH: begin
                    if (!bus.i_clk_en) begin
                        state_r      <= BYPASS;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b0;
                        tick_r       <= 1'b1;
                        bypass_sel_r <= 1'b1;
                    end else if (cnt_r == hi_last_s) begin
                        state_r      <= LOW;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b0;
                        tick_r       <= 1'b0;
                        bypass_sel_r <= 1'b0;
                    end else begin
                        cnt_r        <= cnt_r + ONE_C;
                        tick_r       <= 1'b0;
                        bypass_sel_r <= 1'b0;
                    end
                end
                LOW: begin
                    if (!bus.i_clk_en || ((cnt_r == lo_last_s) && !start_ok_s)) begin
                        state_r      <= BYPASS;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b0;
                        tick_r       <= 1'b1;
                        bypass_sel_r <= 1'b1;
                    end else if (cnt_r == lo_last_s) begin
                        state_r      <= HIGH;
                        ratio_r      <= bus.i_div_ratio;
                        cnt_r        <= ZERO_C;
                        div_r        <= 1'b1;
                        tick_r       <= 1'b1;
                        bypass_sel_r <= 1'b0;
                    end else begin
                        cnt_r        <= cnt_r + ONE_C;
                        tick_r       <= 1'b0;
                        bypass_sel_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= ZERO_C;
                    ratio_r      <= ZERO_C;
                    div_r        <= 1'b0;
                    tick_r       <= 1'b0;
                    bypass_sel_r <= 1'b0;
                end
            endcase
        end
    end

    // Inline 2:1 clock mux; its select is a flop, so it never switches combinationally.
    assign bus.o_div_clk = bypass_sel_r ? i_clk : div_r;
    assign bus.o_tick    = tick_r;

endmodule

// File: doc/sys_clk_div.md
# sys_clk_div

Integer clock divider that sits directly downstream of the system reset synchronizer. It is clocked by the reference clock and reset by the synchronized, active-low reset that the synchronizer produces. It generates the UART bit-rate clock from a runtime-programmable ratio, supports odd and even ratios, and bypasses to the reference clock when disabled or when the ratio is below 2. A one-cycle `o_tick` strobe in the `i_clk` domain marks each rising edge of the divided clock, so logic in the `i_clk` domain can act on it without crossing clocks.

## Interface
- `RATIO_W`, default 8: width of the divide ratio; maximum ratio is 2^RATIO_W − 1.
- `i_clk`  in  1: reference clock.
- `i_rst`  in  1: asynchronous, active-low reset; it comes from the reset synchronizer, so its deassertion is already synchronous to `i_clk`.
- `i_clk_en`  in  1: divider enable. When 0, the block bypasses.
- `i_div_ratio`  in  RATIO_W: divide ratio N. Values 0 and 1 mean bypass.
- `o_div_clk`  out  1: divided clock. In bypass it is `i_clk` itself.
- `o_tick`  out  1: registered strobe, 1 in the `i_clk` cycle in which `o_div_clk` rises.

## Operation
- States: IDLE, BYPASS, HIGH, LOW. The state, a phase counter (RATIO_W bits), the latched ratio `ratio_q`, the divided-clock register `div_q` and the registered `o_tick` are all reset asynchronously by `i_rst` = 0.
- Reset values:
  - state = IDLE
  - counter = 0
  - `ratio_q` = 0
  - `div_q` = 0
  - `o_tick` = 0
  - `o_div_clk` = 0, because the bypass select is 0 in IDLE.
- Phase lengths for a latched ratio N:
  - High phase `hi_len` = floor(N/2) cycles.
  - Low phase `lo_len` = N − floor(N/2) cycles.
  - Examples: N=2 gives H1 L1; N=3 gives H1 L2; N=4 gives H2 L2; N=5 gives H2 L3.
- "Start period" means: latch `ratio_q` ← `i_div_ratio`, set `div_q` = 1, clear the counter, assert `o_tick`.
- IDLE:
  - If `i_clk_en` = 1 and `i_div_ratio` ≥ 2: start period and go to HIGH.
  - Otherwise go to BYPASS.
- BYPASS:
  - `o_div_clk` = `i_clk` through a 2:1 mux whose select is the registered state, so the select never changes combinationally.
  - `o_tick` = 1 every cycle.
  - When `i_clk_en` = 1 and `i_div_ratio` ≥ 2: start period and go to HIGH.
- HIGH:
  - The counter increments each cycle.
  - At counter = `hi_len` − 1: clear the counter, set `div_q` = 0, go to LOW.
- LOW:
  - The counter increments each cycle.
  - At counter = `lo_len` − 1: if `i_clk_en` = 1 and `i_div_ratio` ≥ 2, start period with the new ratio and go to HIGH; otherwise set `div_q` = 0 and go to BYPASS.
- `i_clk_en` = 0 during HIGH or LOW aborts the period: BYPASS is entered on the next edge, with the counter cleared and `div_q` = 0.
- Ratio changes in the middle of a period are ignored. `ratio_q` updates only when a period starts, so every period is complete and glitch-free.
- The counter compares against values derived from `ratio_q`, never from `i_div_ratio`.

## Timing
- From leaving IDLE/BYPASS into HIGH, `o_div_clk` rises at the same `i_clk` edge that registers `div_q` = 1, and `o_tick` is high for that same cycle.
- Steady state: `o_div_clk` period = N `i_clk` cycles, and `o_tick` pulses exactly once per period.
- A new ratio takes effect at the first rising edge of `o_div_clk` after `i_div_ratio` changes.
- Entering or leaving bypass may produce a shortened `o_div_clk` pulse. Downstream logic holds in reset or ignores the clock while reprogramming.
- Reset asserted mid-period: outputs go to their reset values immediately, asynchronously. After release, IDLE lasts exactly one cycle.

## Structure
- Package `sys_clk_div_pkg` holds:
  - the state enum (IDLE, BYPASS, HIGH, LOW);
  - the constant `MIN_RATIO` = 2.
- Single module with no sub-modules. The output clock mux is an inline 2:1 select, flagged for a clock-mux cell in synthesis constraints.

## Test plan
- Reset, then `i_clk_en`=1 and N=4 → first cycle after release is IDLE; `o_div_clk` is then 1,1,0,0 repeating; `o_tick` is high on the first of every 4 cycles.
- N=5 → high for 2 cycles, low for 3, period 5; `o_tick` every 5 cycles.
- N=2 → `o_div_clk` toggles every cycle; `o_tick` every 2 cycles.
- N changes from 4 to 6 in the middle of a HIGH phase → the current 4-cycle period completes, the next period is H3 L3, and the `o_tick` spacing goes 4 then 6.
- `i_clk_en` dropped in the middle of a LOW phase, or N set to 1 → BYPASS next edge (or next boundary for N=1); `o_div_clk` follows `i_clk`; `o_tick` is high every cycle.
- `i_rst` asserted during HIGH with N=8 → `o_div_clk` = 0 and `o_tick` = 0 immediately; after release, IDLE for 1 cycle, then a fresh 8-cycle period.
